// File: rtl/latex_stream_checker_pkg.sv
// ---------------------------------------------------------------------------
// latex_stream_pkg
// Shared definitions for the LaTeX character-stream checker: capture FSM
// states, the NUL terminator byte, result widths and the rotate-XOR checksum
// step. The checksum step is shared by RTL and any model or transmitter-side
// self-check so that every user computes the signature identically.
// ---------------------------------------------------------------------------
package latex_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam int         LEN_W     = 10;
  localparam int         SUM_W     = 16;

  // Rotate the running sum left by one, then fold the new byte into the low half.
  function automatic logic [SUM_W-1:0] cksum_step(input logic [SUM_W-1:0] sum16,
                                                  input logic [7:0]       byte8);
    return {sum16[SUM_W-2:0], sum16[SUM_W-1]} ^ {8'h00, byte8};
  endfunction

endpackage

// File: rtl/latex_stream_checker_side_accum.sv
// ---------------------------------------------------------------------------
// stream_side_accum
// Per-side accumulator for one ASCII byte stream: counts non-NUL bytes, folds
// them into the rotate-XOR checksum and latches the terminated flag on the
// first NUL. Once terminated, later bytes of the capture are ignored.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_clear     synchronous clear at the start of a capture
//   i_beat      accepted beat strobe (already qualified by the FSM)
//   i_byte      byte for this side
//   o_len       non-NUL byte count
//   o_sum       running checksum
//   o_term_nxt  terminated flag as it will be after the current beat
// ---------------------------------------------------------------------------
module stream_side_accum
  import latex_stream_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_beat,
  input  logic [7:0]       i_byte,
  output logic [LEN_W-1:0] o_len,
  output logic [SUM_W-1:0] o_sum,
  output logic             o_term_nxt
);

  logic             r_term;
  logic [LEN_W-1:0] r_len;
  logic [SUM_W-1:0] r_sum;
  logic             w_nul;
  logic             w_accept;

  assign w_nul      = (i_byte == ASCII_NUL);
  assign w_accept   = i_beat & ~r_term;
  // Lets the FSM decide on the terminating beat itself rather than a cycle late.
  assign o_term_nxt = r_term | (w_accept & w_nul);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_term <= 1'b0;
      r_len  <= '0;
      r_sum  <= '0;
    end else if (w_accept) begin
      if (w_nul) begin
        r_term <= 1'b1;
      end else begin
        r_len <= r_len + 1'b1;
        r_sum <= cksum_step(r_sum, i_byte);
      end
    end
  end

  assign o_len = r_len;
  assign o_sum = r_sum;

endmodule

// File: rtl/latex_stream_checker.sv
// ---------------------------------------------------------------------------
// latex_stream_checker
// Captures the paired LaTeX byte streams (function on lhs, Laplace transform
// on rhs), detects each side's NUL terminator and reports per-side length and
// rotate-XOR checksum, plus an overflow flag when MAX_LEN beats pass before
// both sides terminate.
//
// Ports:
//   clk, rst            clock / synchronous active-high reset
//   arm                 start a capture (only honoured in IDLE)
//   char_valid          beat strobe qualifying lhs/rhs
//   lhs, rhs            function-side / transform-side ASCII bytes
//   busy                high while capturing
//   done                one-cycle pulse when a capture ends
//   err_overflow        last capture hit MAX_LEN with a side unterminated
//   lhs_len, rhs_len    non-NUL byte counts, held until the next arm
//   lhs_sum, rhs_sum    checksums, held until the next arm
// ---------------------------------------------------------------------------
module latex_stream_checker
  import latex_stream_pkg::*;
#(
  parameter int MAX_LEN = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             char_valid,
  input  logic [7:0]       lhs,
  input  logic [7:0]       rhs,
  output logic             busy,
  output logic             done,
  output logic             err_overflow,
  output logic [LEN_W-1:0] lhs_len,
  output logic [LEN_W-1:0] rhs_len,
  output logic [SUM_W-1:0] lhs_sum,
  output logic [SUM_W-1:0] rhs_sum
);

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic             w_beat;
  logic             w_clear;
  logic             w_set_ovf;
  logic             w_lhs_term_nxt;
  logic             w_rhs_term_nxt;

  // Beats outside CAPTURE are dropped here, so the accumulators never see them.
  assign w_beat    = char_valid & (r_state == CAPTURE);
  assign w_cnt_nxt = r_cnt + 1'b1;

  stream_side_accum u_lhs (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clear    (w_clear),
    .i_beat     (w_beat),
    .i_byte     (lhs),
    .o_len      (lhs_len),
    .o_sum      (lhs_sum),
    .o_term_nxt (w_lhs_term_nxt)
  );

  stream_side_accum u_rhs (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clear    (w_clear),
    .i_beat     (w_beat),
    .i_byte     (rhs),
    .o_len      (rhs_len),
    .o_sum      (rhs_sum),
    .o_term_nxt (w_rhs_term_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_set_ovf   = 1'b0;
    case (r_state)
      IDLE: begin
        if (arm) begin
          w_state_nxt = CAPTURE;
          w_clear     = 1'b1;
        end
      end
      CAPTURE: begin
        if (w_beat) begin
          // Termination wins over the limit, so both sides ending on the
          // MAX_LEN-th beat is a clean finish.
          if (w_lhs_term_nxt && w_rhs_term_nxt) begin
            w_state_nxt = DONE;
          end else if (w_cnt_nxt == MAX_CNT) begin
            w_state_nxt = DONE;
            w_set_ovf   = 1'b1;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Status flags are registered from the next state so they line up with it.
      r_busy  <= (w_state_nxt == CAPTURE);
      r_done  <= (w_state_nxt == DONE);
      if (w_clear) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_beat) begin
          r_cnt <= w_cnt_nxt;
        end
        if (w_set_ovf) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign err_overflow = r_ovf;

endmodule

// File: tb/tb_latex_stream_checker.sv
module tb_latex_stream_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  lhs = 8'h00;
  logic [7:0]  rhs = 8'h00;

  logic        busy, done, err_overflow;
  logic [9:0]  lhs_len, rhs_len;
  logic [15:0] lhs_sum, rhs_sum;
  logic        busy4, done4, ovf4;
  logic [9:0]  lhs_len4, rhs_len4;
  logic [15:0] lhs_sum4, rhs_sum4;

  always #5 clk = ~clk;

  latex_stream_checker #(.MAX_LEN(512)) dut (
    .clk(clk), .rst(rst), .arm(arm), .char_valid(char_valid), .lhs(lhs), .rhs(rhs),
    .busy(busy), .done(done), .err_overflow(err_overflow),
    .lhs_len(lhs_len), .rhs_len(rhs_len), .lhs_sum(lhs_sum), .rhs_sum(rhs_sum)
  );

  latex_stream_checker #(.MAX_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .arm(arm), .char_valid(char_valid), .lhs(lhs), .rhs(rhs),
    .busy(busy4), .done(done4), .err_overflow(ovf4),
    .lhs_len(lhs_len4), .rhs_len(rhs_len4), .lhs_sum(lhs_sum4), .rhs_sum(rhs_sum4)
  );

  // {busy, done, err_overflow, lhs_len, rhs_len, lhs_sum, rhs_sum}
  logic [54:0] v512, v4;
  assign v512 = {busy, done, err_overflow, lhs_len, rhs_len, lhs_sum, rhs_sum};
  assign v4   = {busy4, done4, ovf4, lhs_len4, rhs_len4, lhs_sum4, rhs_sum4};

  int vecs = 0;
  int errs = 0;

  // Stimulus arrays: one entry per valid beat.
  logic [7:0] sl[64];
  logic [7:0] sr[64];
  int         n;

  // Reference model results.
  int          exp_exit;
  logic        exp_ovf;
  logic [9:0]  exp_ll, exp_rl;
  logic [15:0] exp_sl, exp_sr;
  logic [54:0] exp_vec, exp_hold;

  // Observations from the stream driver.
  int          obs_done_beat;
  logic        obs_busy_arm;
  logic        obs_spurious;
  logic [54:0] obs_vec, obs_hold;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_beat(input logic [7:0] l, input logic [7:0] r);
    lhs = l;
    rhs = r;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
  endtask

  function automatic int fold(input int s, input logic [7:0] b);
    return (((s << 1) | (s >> 15)) & 'hFFFF) ^ int'(b);
  endfunction

  // Declarative model: each side's length is the position of its first NUL,
  // capped by where the capture stops; the capture stops one beat after the
  // later of the two NULs, or at maxl beats.
  task automatic model(input int maxl);
    int fl, fr, eb, s, ll, rl;
    fl = 1 << 20;
    fr = 1 << 20;
    for (int i = n - 1; i >= 0; i--) begin
      if (sl[i] == 8'h00) fl = i;
      if (sr[i] == 8'h00) fr = i;
    end
    eb = ((fl > fr) ? fl : fr) + 1;
    if (eb <= maxl) begin
      exp_exit = eb;
      exp_ovf  = 1'b0;
    end else begin
      exp_exit = maxl;
      exp_ovf  = 1'b1;
    end
    ll = (fl < exp_exit) ? fl : exp_exit;
    rl = (fr < exp_exit) ? fr : exp_exit;
    s = 0;
    for (int i = 0; i < ll; i++) s = fold(s, sl[i]);
    exp_sl = 16'(s);
    s = 0;
    for (int i = 0; i < rl; i++) s = fold(s, sr[i]);
    exp_sr = 16'(s);
    exp_ll   = 10'(ll);
    exp_rl   = 10'(rl);
    exp_vec  = {1'b0, 1'b1, exp_ovf, exp_ll, exp_rl, exp_sl, exp_sr};
    exp_hold = {1'b0, 1'b0, exp_ovf, exp_ll, exp_rl, exp_sl, exp_sr};
  endtask

  // Arms, then feeds sl/sr with gaps of gmin..gmax idle cycles; records the
  // outputs of the selected instance at the done pulse and one cycle later.
  task automatic run_stream(input int gmin, input int gmax, input bit sel);
    int g;
    obs_done_beat = -1;
    obs_spurious  = 1'b0;
    obs_vec       = '0;
    obs_hold      = '0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    obs_busy_arm = sel ? busy4 : busy;
    for (int i = 0; i < n && obs_done_beat < 0; i++) begin
      drive_beat(sl[i], sr[i]);
      if (sel ? done4 : done) begin
        obs_done_beat = i;
        obs_vec = sel ? v4 : v512;
      end else begin
        g = int'($urandom_range(gmax, gmin));
        for (int k = 0; k < g; k++) begin
          tick();
          if (sel ? done4 : done) obs_spurious = 1'b1;
        end
      end
    end
    if (obs_done_beat >= 0) begin
      tick();
      obs_hold = sel ? v4 : v512;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vecs++;
    if (v512 !== 55'd0) begin
      errs++;
      $display("FAIL reset_512: got %h expected %h", v512, 55'd0);
    end
    vecs++;
    if (v4 !== 55'd0) begin
      errs++;
      $display("FAIL reset_4: got %h expected %h", v4, 55'd0);
    end
  endtask

  task automatic test_overflow;
    pulse_rst();
    n = 4;
    for (int i = 0; i < 4; i++) begin
      sl[i] = 8'h78;
      sr[i] = 8'h78;
    end
    model(4);
    run_stream(0, 0, 1'b1);
    vecs++;
    if (obs_done_beat !== 3) begin
      errs++;
      $display("FAIL ovf_done_beat: got %0d expected %0d", obs_done_beat, 3);
    end
    vecs++;
    if (obs_vec !== exp_vec) begin
      errs++;
      $display("FAIL ovf_vec: got %h expected %h", obs_vec, exp_vec);
    end
    vecs++;
    if (obs_vec[31:0] !== {16'h02A8, 16'h02A8} || obs_vec[52] !== 1'b1) begin
      errs++;
      $display("FAIL ovf_const: got sums %h ovf %b expected 02a802a8 ovf 1", obs_vec[31:0], obs_vec[52]);
    end
    pulse_rst();
  endtask

  task automatic test_basic;
    pulse_rst();
    n = 3;
    sl[0] = "a"; sl[1] = "b"; sl[2] = 8'h00;
    sr[0] = "c"; sr[1] = 8'h00; sr[2] = 8'h00;
    model(512);
    run_stream(0, 0, 1'b0);
    vecs++;
    if (obs_busy_arm !== 1'b1) begin
      errs++;
      $display("FAIL basic_busy_after_arm: got %b expected 1", obs_busy_arm);
    end
    vecs++;
    if (obs_done_beat !== 2) begin
      errs++;
      $display("FAIL basic_done_beat: got %0d expected 2", obs_done_beat);
    end
    vecs++;
    if (obs_vec !== exp_vec) begin
      errs++;
      $display("FAIL basic_vec: got %h expected %h", obs_vec, exp_vec);
    end
    vecs++;
    if (obs_vec[31:0] !== {16'h00A0, 16'h0063}) begin
      errs++;
      $display("FAIL basic_sums: got %h expected 00a00063", obs_vec[31:0]);
    end
    vecs++;
    if (obs_hold !== exp_hold) begin
      errs++;
      $display("FAIL basic_hold: got %h expected %h", obs_hold, exp_hold);
    end
  endtask

  task automatic test_min;
    n = 1;
    sl[0] = 8'h00;
    sr[0] = 8'h00;
    model(512);
    run_stream(0, 0, 1'b0);
    vecs++;
    if (obs_busy_arm !== 1'b1 || obs_done_beat !== 0) begin
      errs++;
      $display("FAIL min_timing: got busy %b done_beat %0d expected busy 1 done_beat 0", obs_busy_arm, obs_done_beat);
    end
    vecs++;
    if (obs_vec !== exp_vec) begin
      errs++;
      $display("FAIL min_vec: got %h expected %h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_gaps;
    n = 4;
    sl[0] = "a"; sl[1] = 8'h00; sl[2] = "z"; sl[3] = "y";
    sr[0] = "b"; sr[1] = "b";   sr[2] = "b"; sr[3] = 8'h00;
    model(512);
    run_stream(2, 2, 1'b0);
    vecs++;
    if (obs_done_beat !== 3 || obs_spurious !== 1'b0) begin
      errs++;
      $display("FAIL gaps_timing: got done_beat %0d spurious %b expected 3 0", obs_done_beat, obs_spurious);
    end
    vecs++;
    if (obs_vec !== exp_vec) begin
      errs++;
      $display("FAIL gaps_vec: got %h expected %h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_rst_mid;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    drive_beat("p", "q");
    drive_beat("p", "q");
    vecs++;
    if ({busy, lhs_len} !== {1'b1, 10'd2}) begin
      errs++;
      $display("FAIL rstmid_pre: got busy %b len %0d expected 1 2", busy, lhs_len);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if (v512 !== 55'd0) begin
      errs++;
      $display("FAIL rstmid_clear: got %h expected %h", v512, 55'd0);
    end
    drive_beat(8'h00, 8'h00);
    tick();
    vecs++;
    if ({busy, done} !== 2'b00) begin
      errs++;
      $display("FAIL rstmid_idle: got busy %b done %b expected 0 0", busy, done);
    end
  endtask

  task automatic test_arm_ignored;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    drive_beat("a", "b");
    arm = 1'b1;
    tick();
    arm = 1'b0;
    vecs++;
    if ({busy, lhs_len, rhs_len} !== {1'b1, 10'd1, 10'd1}) begin
      errs++;
      $display("FAIL armcap: got busy %b lens %0d %0d expected 1 1 1", busy, lhs_len, rhs_len);
    end
    drive_beat(8'h00, 8'h00);
    vecs++;
    if ({done, busy, lhs_len, rhs_len, lhs_sum, rhs_sum} !==
        {1'b1, 1'b0, 10'd1, 10'd1, 16'h0061, 16'h0062}) begin
      errs++;
      $display("FAIL armcap_done: got done %b busy %b lens %0d %0d sums %h %h expected 1 0 1 1 0061 0062",
               done, busy, lhs_len, rhs_len, lhs_sum, rhs_sum);
    end
    arm = 1'b1;
    tick();
    arm = 1'b0;
    vecs++;
    if ({busy, done, lhs_len} !== {1'b0, 1'b0, 10'd1}) begin
      errs++;
      $display("FAIL armdone_idle: got busy %b done %b len %0d expected 0 0 1", busy, done, lhs_len);
    end
    tick();
    vecs++;
    if ({busy, lhs_len} !== {1'b0, 10'd1}) begin
      errs++;
      $display("FAIL armdone_ignored: got busy %b len %0d expected 0 1", busy, lhs_len);
    end
  endtask

  task automatic test_back_to_back;
    pulse_rst();
    arm = 1'b1;
    tick();
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL b2b_busy1: got %b expected 1", busy);
    end
    drive_beat("q", 8'h00);
    drive_beat(8'h00, "r");
    vecs++;
    if ({done, lhs_len, rhs_len, lhs_sum, rhs_sum} !== {1'b1, 10'd1, 10'd0, 16'h0071, 16'h0000}) begin
      errs++;
      $display("FAIL b2b_first: got done %b lens %0d %0d sums %h %h expected 1 1 0 0071 0000",
               done, lhs_len, rhs_len, lhs_sum, rhs_sum);
    end
    tick();
    vecs++;
    if ({busy, done, lhs_len, lhs_sum} !== {1'b0, 1'b0, 10'd1, 16'h0071}) begin
      errs++;
      $display("FAIL b2b_idle: got busy %b done %b len %0d sum %h expected 0 0 1 0071", busy, done, lhs_len, lhs_sum);
    end
    tick();
    vecs++;
    if ({busy, lhs_len, lhs_sum} !== {1'b1, 10'd0, 16'h0000}) begin
      errs++;
      $display("FAIL b2b_second: got busy %b len %0d sum %h expected 1 0 0000", busy, lhs_len, lhs_sum);
    end
    arm = 1'b0;
    drive_beat(8'h00, 8'h00);
    vecs++;
    if ({done, lhs_len, rhs_len} !== {1'b1, 10'd0, 10'd0}) begin
      errs++;
      $display("FAIL b2b_second_done: got done %b lens %0d %0d expected 1 0 0", done, lhs_len, rhs_len);
    end
    tick();
  endtask

  task automatic test_random;
    int ll, rl;
    pulse_rst();
    for (int it = 0; it < 40; it++) begin
      ll = int'($urandom_range(10, 0));
      rl = int'($urandom_range(10, 0));
      n  = ((ll > rl) ? ll : rl) + 1 + int'($urandom_range(2, 0));
      for (int i = 0; i < n; i++) begin
        sl[i] = (i < ll) ? 8'($urandom_range(255, 1)) : (i == ll) ? 8'h00 : 8'($urandom_range(255, 0));
        sr[i] = (i < rl) ? 8'($urandom_range(255, 1)) : (i == rl) ? 8'h00 : 8'($urandom_range(255, 0));
      end
      model(512);
      run_stream(0, 1, 1'b0);
      vecs++;
      if (obs_done_beat !== exp_exit - 1 || obs_spurious !== 1'b0) begin
        errs++;
        $display("FAIL rand_timing it=%0d: got done_beat %0d spurious %b expected %0d 0",
                 it, obs_done_beat, obs_spurious, exp_exit - 1);
        pulse_rst();
      end
      vecs++;
      if (obs_vec !== exp_vec) begin
        errs++;
        $display("FAIL rand_vec it=%0d: got %h expected %h", it, obs_vec, exp_vec);
      end
      vecs++;
      if (obs_hold !== exp_hold) begin
        errs++;
        $display("FAIL rand_hold it=%0d: got %h expected %h", it, obs_hold, exp_hold);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    test_reset();
    test_overflow();
    test_basic();
    test_min();
    test_gaps();
    test_rst_mid();
    test_arm_ignored();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
